noc_rr_crossbar: RTL and testbench

Parametrised successor to the plain mux switch: an INPUTS x OUTPUTS wormhole crossbar with built-in per-output round-robin arbitration and packet locking.
- No external switch-control logic required; each output owns an arbiter FSM that grants one input per packet and holds the path until the tail flit.
- Optional per-output 2-entry skid buffer breaks the ready/valid combinational paths between routers.

---
 rtl/noc_rr_crossbar_pkg.sv | 42 ++++
 rtl/noc_rr_crossbar_if.sv | 33 +++
 rtl/noc_rr_crossbar_skid.sv | 50 +++++
 rtl/noc_rr_crossbar.sv | 134 +++++++++++++
 tb/tb_noc_rr_crossbar.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_rr_crossbar_pkg.sv
// Shared types and the round-robin helper for noc_rr_crossbar.
// Arbiter pointer and index fields are sized for up to 32 inputs.
package noc_xbar_pkg;

    localparam int XB_DW = 32;

    typedef enum logic {
        XB_IDLE,
        XB_LOCKED
    } xb_state_e;

    typedef struct packed {
        logic [XB_DW-1:0] data;
        logic             head;
        logic             tail;
    } flit_t;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } rr_res_t;

    // First requester after ptr, wrapping modulo n.
    function automatic rr_res_t rr_pick(
        input logic [31:0] req,
        input logic [4:0]  ptr,
        input int unsigned n
    );
        rr_res_t     r;
        int unsigned k_idx;
        r = '0;
        for (int unsigned k = 1; k <= 32; k++) begin
            k_idx = (32'(ptr) + k) % n;
            if (k <= n && !r.found && req[5'(k_idx)]) begin
                r.found = 1'b1;
                r.idx   = 5'(k_idx);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_rr_crossbar_if.sv
// Crossbar-side bundle: input channels, output channels and status.
// master drives flits in and accepts out; slave is the crossbar.
interface noc_rr_crossbar_if #(
    parameter int INPUTS      = 5,
    parameter int OUTPUTS     = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int ROUTE_WIDTH = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1
) ();

    logic [INPUTS-1:0][DATA_WIDTH-1:0]   data_in;
    logic [INPUTS-1:0]                   valid_in;
    logic [INPUTS-1:0]                   head_in;
    logic [INPUTS-1:0]                   tail_in;
    logic [INPUTS-1:0][ROUTE_WIDTH-1:0]  route_in;
    logic [INPUTS-1:0]                   ready_in;
    logic [OUTPUTS-1:0][DATA_WIDTH-1:0]  data_out;
    logic [OUTPUTS-1:0]                  valid_out;
    logic [OUTPUTS-1:0]                  tail_out;
    logic [OUTPUTS-1:0]                  ready_out;
    logic [OUTPUTS-1:0]                  out_locked;
    logic [INPUTS-1:0]                   route_err;

    modport master (
        output data_in, valid_in, head_in, tail_in, route_in, ready_out,
        input  ready_in, data_out, valid_out, tail_out, out_locked, route_err
    );

    modport slave (
        input  data_in, valid_in, head_in, tail_in, route_in, ready_out,
        output ready_in, data_out, valid_out, tail_out, out_locked, route_err
    );

endinterface

// File: rtl/noc_rr_crossbar_skid.sv
// Two-entry FIFO; ready depends only on registered occupancy.
// Output data is forced to zero while empty.
module noc_skid_buffer #(
    parameter int W = 33
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i
);

    logic [W-1:0] mem_q [2];
    logic         wr_q, wr_d;
    logic         rd_q, rd_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push, pop;

    assign in_ready_o  = (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = out_valid_o ? mem_q[rd_q] : '0;

    always_comb begin
        push  = in_valid_i & in_ready_o;
        pop   = out_valid_o & out_ready_i;
        wr_d  = wr_q ^ push;
        rd_d  = rd_q ^ pop;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= in_data_i;
    end

endmodule

// File: rtl/noc_rr_crossbar.sv
// Wormhole crossbar: one round-robin arbiter per output locks a path
// from head to tail; optional skid buffer on each output.
module noc_rr_crossbar
    import noc_xbar_pkg::*;
#(
    parameter int INPUTS      = 5,
    parameter int OUTPUTS     = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int ROUTE_WIDTH = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1,
    parameter int OUT_REG     = 1
) (
    input logic              clk,
    input logic              rst,
    noc_rr_crossbar_if.slave bus
);

    localparam int IW = (INPUTS > 1) ? $clog2(INPUTS) : 1;

    xb_state_e     st_q  [OUTPUTS];
    xb_state_e     st_d  [OUTPUTS];
    logic [IW-1:0] own_q [OUTPUTS];
    logic [IW-1:0] own_d [OUTPUTS];
    logic [IW-1:0] rr_q  [OUTPUTS];
    logic [IW-1:0] rr_d  [OUTPUTS];

    logic [INPUTS-1:0]  err_q, err_d;
    logic [INPUTS-1:0]  busy, bad, rdy;
    logic [31:0]        req;
    rr_res_t            pick;

    logic [OUTPUTS-1:0]                 sv, sr, stl, lock;
    logic [OUTPUTS-1:0][DATA_WIDTH-1:0] sd;
    logic [OUTPUTS-1:0]                 vo, tq;
    logic [OUTPUTS-1:0][DATA_WIDTH-1:0] dq;

    always_comb begin
        for (int o = 0; o < OUTPUTS; o++) begin
            lock[o] = (st_q[o] == XB_LOCKED);
            sv[o]   = lock[o] & bus.valid_in[own_q[o]];
            stl[o]  = lock[o] & bus.tail_in[own_q[o]];
            sd[o]   = lock[o] ? bus.data_in[own_q[o]] : '0;
        end
    end

    always_comb begin
        busy = '0;
        rdy  = '0;
        req  = '0;
        pick = '0;
        for (int o = 0; o < OUTPUTS; o++) begin
            if (st_q[o] == XB_LOCKED) busy[own_q[o]] = 1'b1;
        end
        for (int j = 0; j < INPUTS; j++) begin
            bad[j] = 32'(bus.route_in[j]) >= 32'(OUTPUTS);
        end
        err_d = err_q | (bus.valid_in & bus.head_in & bad);
        for (int o = 0; o < OUTPUTS; o++) begin
            st_d[o]  = st_q[o];
            own_d[o] = own_q[o];
            rr_d[o]  = rr_q[o];
            // Inputs already holding a path may not claim a second one.
            req = '0;
            for (int j = 0; j < INPUTS; j++) begin
                req[j] = bus.valid_in[j] & bus.head_in[j] & ~bad[j]
                       & ~err_q[j] & ~busy[j]
                       & (32'(bus.route_in[j]) == o);
            end
            unique case (st_q[o])
                XB_IDLE: begin
                    pick = rr_pick(req, 5'(rr_q[o]), INPUTS);
                    if (pick.found) begin
                        st_d[o]  = XB_LOCKED;
                        own_d[o] = IW'(pick.idx);
                    end
                end
                XB_LOCKED: begin
                    rdy[own_q[o]] = sr[o];
                    if (sv[o] && sr[o] && stl[o]) begin
                        st_d[o] = XB_IDLE;
                        rr_d[o] = own_q[o];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < OUTPUTS; o++) begin
                st_q[o]  <= XB_IDLE;
                own_q[o] <= '0;
                rr_q[o]  <= IW'(INPUTS - 1);
            end
            err_q <= '0;
        end else begin
            st_q  <= st_d;
            own_q <= own_d;
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

    for (genvar o = 0; o < OUTPUTS; o++) begin : g_out
        if (OUT_REG != 0) begin : g_reg
            logic [DATA_WIDTH:0] q;
            noc_skid_buffer #(.W(DATA_WIDTH + 1)) u_skid (
                .clk_i       (clk),
                .rst_i       (rst),
                .in_valid_i  (sv[o]),
                .in_data_i   ({stl[o], sd[o]}),
                .in_ready_o  (sr[o]),
                .out_valid_o (vo[o]),
                .out_data_o  (q),
                .out_ready_i (bus.ready_out[o])
            );
            assign dq[o] = q[DATA_WIDTH-1:0];
            assign tq[o] = q[DATA_WIDTH];
        end else begin : g_comb
            assign vo[o] = sv[o];
            assign dq[o] = sd[o];
            assign tq[o] = stl[o];
            assign sr[o] = bus.ready_out[o];
        end
    end

    assign bus.ready_in   = rdy;
    assign bus.valid_out  = vo;
    assign bus.data_out   = dq;
    assign bus.tail_out   = tq;
    assign bus.out_locked = lock;
    assign bus.route_err  = err_q;

endmodule

// File: tb/tb_noc_rr_crossbar.sv
// Scoreboard bench for noc_rr_crossbar: accepted flits are queued per
// (input, output) pair and matched by a monitor on every output transfer.
module tb_noc_rr_crossbar;
    import noc_xbar_pkg::*;

    localparam int NI = 5;
    localparam int NO = 5;
    localparam int DW = 32;
    localparam int RW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    noc_rr_crossbar_if #(
        .INPUTS(NI), .OUTPUTS(NO), .DATA_WIDTH(DW), .ROUTE_WIDTH(RW)
    ) bus ();

    noc_rr_crossbar #(
        .INPUTS(NI), .OUTPUTS(NO), .DATA_WIDTH(DW),
        .ROUTE_WIDTH(RW), .OUT_REG(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        flit_t f;
        int    dst;
    } sfl_t;

    sfl_t pend [NI][$];
    sfl_t expq [NI*NO][$];
    int   head_ord [NO][$];
    int   cur_src [NO];
    int   xfer_cnt [NO];
    int   acc_cnt [NI];
    bit   rnd_gap = 1'b0;
    bit   rnd_ro  = 1'b0;
    logic [NO-1:0] ro_val = '1;
    int   checks = 0;
    int   failures = 0;
    sfl_t drv_s, mon_e;
    int   mon_src;

    initial begin
        for (int o = 0; o < NO; o++) begin
            cur_src[o]  = -1;
            xfer_cnt[o] = 0;
        end
        for (int j = 0; j < NI; j++) acc_cnt[j] = 0;
    end

    // Driver: present queue heads, record accepted flits as expected output.
    always @(negedge clk) begin
        for (int j = 0; j < NI; j++) begin
            if (!rst && pend[j].size() > 0 &&
                !(rnd_gap && $urandom_range(3) == 0)) begin
                bus.valid_in[j] = 1'b1;
                bus.data_in[j]  = pend[j][0].f.data;
                bus.head_in[j]  = pend[j][0].f.head;
                bus.tail_in[j]  = pend[j][0].f.tail;
                bus.route_in[j] = RW'(pend[j][0].dst);
            end else begin
                bus.valid_in[j] = 1'b0;
                bus.data_in[j]  = '0;
                bus.head_in[j]  = 1'b0;
                bus.tail_in[j]  = 1'b0;
                bus.route_in[j] = '0;
            end
        end
        bus.ready_out = rnd_ro ? NO'($urandom) : ro_val;
        #4;
        for (int j = 0; j < NI; j++) begin
            if (!rst && bus.valid_in[j] && bus.ready_in[j]) begin
                drv_s = pend[j].pop_front();
                acc_cnt[j]++;
                expq[j*NO + drv_s.dst].push_back(drv_s);
            end
        end
    end

    // Monitor: each output transfer must be the next flit of the packet
    // holding that output, or a queued head destined for it.
    always @(negedge clk) begin
        #4;
        if (!rst) begin
            for (int o = 0; o < NO; o++) begin
                if (bus.valid_out[o] && bus.ready_out[o]) begin
                    xfer_cnt[o]++;
                    checks++;
                    mon_src = cur_src[o];
                    if (mon_src < 0) begin
                        for (int j = 0; j < NI; j++) begin
                            if (mon_src < 0 && expq[j*NO+o].size() > 0 &&
                                expq[j*NO+o][0].f.head &&
                                expq[j*NO+o][0].f.data == bus.data_out[o])
                                mon_src = j;
                        end
                    end
                    if (mon_src < 0 || expq[mon_src*NO+o].size() == 0) begin
                        failures++;
                        $display("FAIL out%0d flit: got data=%h tail=%b, want no transfer",
                                 o, bus.data_out[o], bus.tail_out[o]);
                    end else begin
                        mon_e = expq[mon_src*NO+o].pop_front();
                        if (bus.data_out[o] !== mon_e.f.data ||
                            bus.tail_out[o] !== mon_e.f.tail) begin
                            failures++;
                            $display("FAIL out%0d flit: got data=%h tail=%b want data=%h tail=%b",
                                     o, bus.data_out[o], bus.tail_out[o],
                                     mon_e.f.data, mon_e.f.tail);
                        end
                        if (mon_e.f.head) head_ord[o].push_back(mon_src);
                        cur_src[o] = mon_e.f.tail ? -1 : mon_src;
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic add_pkt(input int j, input int dst, input int len,
                           input logic [31:0] base);
        sfl_t s;
        for (int i = 0; i < len; i++) begin
            s.f.data = base + 32'(i);
            s.f.head = (i == 0);
            s.f.tail = (i == len - 1);
            s.dst    = dst;
            pend[j].push_back(s);
        end
    endtask

    function automatic int left();
        int n = 0;
        for (int j = 0; j < NI; j++) n += pend[j].size();
        for (int k = 0; k < NI*NO; k++) n += expq[k].size();
        return n;
    endfunction

    function automatic logic [63:0] ord_val(input int o);
        logic [63:0] v = '0;
        foreach (head_ord[o][k]) v = (v << 8) | 64'(head_ord[o][k]);
        return v;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (left() != 0 && n < budget) begin
            cyc(1);
            n++;
        end
        chk(name, 64'(left()), 64'd0);
    endtask

    initial begin
        int x3, x4, a0, n;
        cyc(2);
        chk("reset valid_out", 64'(bus.valid_out), 64'd0);
        chk("reset data_out", 64'(|bus.data_out), 64'd0);
        chk("reset tail_out", 64'(bus.tail_out), 64'd0);
        chk("reset out_locked", 64'(bus.out_locked), 64'd0);
        chk("reset ready_in", 64'(bus.ready_in), 64'd0);
        chk("reset route_err", 64'(bus.route_err), 64'd0);
        rst = 1'b0;
        cyc(1);

        add_pkt(0, 2, 1, 32'hA5);
        cyc(1);
        chk("single locked c1", 64'(bus.out_locked), 64'h04);
        chk("single valid c1", 64'(bus.valid_out), 64'h00);
        cyc(1);
        chk("single valid c2", 64'(bus.valid_out), 64'h04);
        chk("single data c2", 64'(bus.data_out[2]), 64'hA5);
        chk("single tail c2", 64'(bus.tail_out[2]), 64'h1);
        chk("single unlocked c2", 64'(bus.out_locked), 64'h00);
        cyc(1);
        chk("single valid c3", 64'(bus.valid_out), 64'h00);
        wait_drain("single drain", 50);

        add_pkt(0, 1, 2, 32'h0100);
        add_pkt(4, 1, 2, 32'h0400);
        wait_drain("prio drain", 50);
        chk("rr reset order out1", ord_val(1), 64'h0004);

        add_pkt(1, 0, 3, 32'h1100);
        add_pkt(3, 0, 3, 32'h1300);
        add_pkt(4, 0, 3, 32'h1400);
        wait_drain("contention drain", 100);
        chk("rr order out0", ord_val(0), 64'h010304);
        head_ord[0].delete();
        add_pkt(4, 0, 2, 32'h2400);
        add_pkt(3, 0, 2, 32'h2300);
        wait_drain("rr ptr drain", 100);
        chk("rr ptr after contention", ord_val(0), 64'h0304);

        head_ord[1].delete();
        add_pkt(2, 1, 4, 32'h10);
        for (int k = 0; k < 8; k++) begin
            ro_val[1] = (k == 3 || k == 4) ? 1'b0 : 1'b1;
            cyc(1);
            if (k == 3) begin
                chk("bp ready_in drop", 64'(bus.ready_in[2]), 64'h0);
                chk("bp valid held", 64'(bus.valid_out[1]), 64'h1);
            end
        end
        ro_val = '1;
        wait_drain("bp drain", 50);
        chk("bp single packet", ord_val(1), 64'h02);

        x3 = xfer_cnt[3];
        x4 = xfer_cnt[4];
        add_pkt(0, 3, 6, 32'h3000);
        add_pkt(1, 4, 6, 32'h4000);
        cyc(8);
        chk("parallel rate out3", 64'(xfer_cnt[3] - x3), 64'd6);
        chk("parallel rate out4", 64'(xfer_cnt[4] - x4), 64'd6);
        wait_drain("parallel drain", 50);

        add_pkt(2, 6, 1, 32'hBAD);
        add_pkt(0, 1, 3, 32'h5000);
        cyc(1);
        chk("route_err set", 64'(bus.route_err), 64'h04);
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            chk("bad input stalled", 64'(bus.ready_in[2]), 64'h0);
        end
        pend[2].delete();
        wait_drain("bad route other ports", 50);
        chk("route_err sticky", 64'(bus.route_err), 64'h04);

        add_pkt(0, 1, 4, 32'h6000);
        a0 = acc_cnt[0];
        n = 0;
        while (acc_cnt[0] < a0 + 2 && n < 20) begin
            cyc(1);
            n++;
        end
        chk("midpkt two accepted", 64'(acc_cnt[0] - a0), 64'd2);
        rst = 1'b1;
        for (int j = 0; j < NI; j++) pend[j].delete();
        for (int k = 0; k < NI*NO; k++) expq[k].delete();
        for (int o = 0; o < NO; o++) cur_src[o] = -1;
        cyc(1);
        rst = 1'b0;
        chk("midrst valid_out", 64'(bus.valid_out), 64'd0);
        chk("midrst out_locked", 64'(bus.out_locked), 64'd0);
        chk("midrst route_err", 64'(bus.route_err), 64'd0);
        chk("midrst ready_in", 64'(bus.ready_in), 64'd0);
        add_pkt(0, 3, 2, 32'h7000);
        cyc(1);
        chk("post rst grant", 64'(bus.out_locked), 64'h08);
        wait_drain("post rst drain", 50);

        rnd_gap = 1'b1;
        rnd_ro  = 1'b1;
        for (int p = 0; p < 6; p++) begin
            for (int j = 0; j < NI; j++) begin
                add_pkt(j, int'($urandom_range(NO - 1)),
                        int'($urandom_range(4, 1)),
                        (32'(j) << 24) | (32'(p) << 8));
            end
        end
        wait_drain("random drain", 4000);
        rnd_gap = 1'b0;
        rnd_ro  = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
